// File: rtl/npc_axi_pkg.sv
// Shared AXI4 read-side definitions for the fetch-path bus masters.
//   axi_resp_e      : AXI response codes
//   BURST_INCR      : arburst encoding for incrementing bursts
//   LEN_SINGLE      : arlen for a single-beat transfer
//   SIZE_4B         : arsize encoding for a 4-byte transfer
//   fetch_state_e   : state encoding of the instruction-fetch read master
//   resp_is_err()   : true for SLVERR / DECERR responses
package npc_axi_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [7:0] LEN_SINGLE = 8'd0;
   localparam logic [2:0] SIZE_4B    = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_RESP,
      ST_WAIT_REL
   } fetch_state_e;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/ifu_axi_rd_master_if.sv
// AXI4 read-address and read-data channels between the fetch read master
// and the memory-side slave.
//   master modport : drives AR channel and rready; receives arready and R channel
//   slave modport  : the mirror image
interface ifu_axi_rd_master_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              arvalid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arready;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;

   modport master (
      output arvalid, araddr, arlen, arsize, arburst, rready,
      input  arready, rvalid, rdata, rresp, rlast
   );

   modport slave (
      input  arvalid, araddr, arlen, arsize, arburst, rready,
      output arready, rvalid, rdata, rresp, rlast
   );
endinterface

// File: rtl/ifu_axi_rd_master.sv
// Single-beat AXI4 read master in front of the instruction fetch unit.
// Converts a level fetch request into one AXI read, returns the selected
// 32-bit instruction word right-aligned with a one-cycle done pulse, and
// re-arms only once the fetch unit drops its request.
//   clk, rst  : clock, synchronous active-high reset
//   req       : level fetch request
//   req_addr  : fetch address, sampled when the request is accepted
//   rd_done   : one-cycle pulse, rd_data / rd_err valid
//   rd_data   : {32'b0, instruction}
//   rd_err    : bus error response or misaligned address
//   busy      : from acceptance up to and including the rd_done cycle
//   m         : AXI read channels (master side)
module ifu_axi_rd_master
   import npc_axi_pkg::*;
#(
   parameter int          ADDR_W     = 64,
   parameter int          DATA_W     = 64,
   parameter logic [2:0]  ARSIZE_VAL = SIZE_4B
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req,
   input  logic [ADDR_W-1:0]    req_addr,
   output logic                 rd_done,
   output logic [DATA_W-1:0]    rd_data,
   output logic                 rd_err,
   output logic                 busy,
   ifu_axi_rd_master_if.master  m
);

   fetch_state_e      state;
   logic [ADDR_W-1:0] addr_q;
   logic              arvalid_q;
   logic              rready_q;

   assign m.arlen   = LEN_SINGLE;
   assign m.arsize  = ARSIZE_VAL;
   assign m.arburst = BURST_INCR;
   assign m.arvalid = arvalid_q;
   assign m.araddr  = addr_q;
   assign m.rready  = rready_q;

   // Single-beat reads: rlast carries no information.
   logic unused_rlast;
   assign unused_rlast = m.rlast;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         rd_done   <= 1'b0;
         rd_data   <= '0;
         rd_err    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rd_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  addr_q <= req_addr;
                  busy   <= 1'b1;
                  if (req_addr[1:0] != 2'b00) begin
                     // Misaligned fetch is answered locally; the bus never sees it.
                     rd_err  <= 1'b1;
                     rd_data <= '0;
                     rd_done <= 1'b1;
                     state   <= ST_RESP;
                  end else begin
                     arvalid_q <= 1'b1;
                     state     <= ST_ADDR;
                  end
               end
            end
            ST_ADDR: begin
               if (m.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state     <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (m.rvalid) begin
                  rready_q <= 1'b0;
                  // The 4-byte fetch lands in one half of the 64-bit beat.
                  rd_data  <= {{(DATA_W-32){1'b0}},
                               addr_q[2] ? m.rdata[DATA_W-1:32] : m.rdata[31:0]};
                  rd_err   <= resp_is_err(m.rresp);
                  rd_done  <= 1'b1;
                  state    <= ST_RESP;
               end
            end
            ST_RESP: begin
               busy  <= 1'b0;
               state <= ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
               // Fetch unit holds req through its hold phase; wait for release.
               if (!req) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_axi_rd_master.sv
module tb_ifu_axi_rd_master;

   logic        clk;
   logic        rst;
   logic        req;
   logic [63:0] req_addr;
   logic        rd_done;
   logic [63:0] rd_data;
   logic        rd_err;
   logic        busy;

   ifu_axi_rd_master_if #(.ADDR_W(64), .DATA_W(64)) ax ();

   ifu_axi_rd_master #(.ADDR_W(64), .DATA_W(64), .ARSIZE_VAL(3'b010)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_addr (req_addr),
      .rd_done  (rd_done),
      .rd_data  (rd_data),
      .rd_err   (rd_err),
      .busy     (busy),
      .m        (ax)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] rdata;
      logic [1:0]  rresp;
      int          ard;
      int          rd;
      int          hold;
      logic [63:0] exp_data;
      logic        exp_err;
      int          exp_ar;
   } vec_t;

   int checks = 0;
   int passed = 0;

   // slave configuration and bookkeeping
   int          cfg_ard, cfg_rd;
   logic [63:0] cfg_rdata;
   logic [1:0]  cfg_rresp;
   bit          junk_en;
   bit          pending_r;
   int          ar_cnt, r_cnt;
   int          ar_hs, arv_cycles, done_cnt, viol;
   logic [63:0] hs_addr, exp_araddr, got_data;
   logic        got_err;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Reference: what one request must produce, from the address rules alone.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      if (v.addr % 4 != 0) begin
         r.exp_data = 64'd0;
         r.exp_err  = 1'b1;
         r.exp_ar   = 0;
      end else begin
         r.exp_data = (v.rdata >> (32 * ((v.addr / 4) % 2))) & 64'hFFFF_FFFF;
         r.exp_err  = (v.rresp >= 2);
         r.exp_ar   = 1;
      end
      return r;
   endfunction

   // One clock: observe DUT after the edge, then drive the slave for the next edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      if (rst) begin
         pending_r  = 0;
         ar_cnt     = 0;
         r_cnt      = 0;
         ax.arready = 1'b0;
         ax.rvalid  = 1'b0;
      end else begin
         if (rd_done) begin
            done_cnt++;
            got_data = rd_data;
            got_err  = rd_err;
            if (ax.arvalid) viol++;
         end
         if (ax.arvalid) begin
            arv_cycles++;
            if (ax.araddr !== exp_araddr) viol++;
         end
         ax.rvalid = 1'b0;
         if (pending_r && ax.rready) begin
            if (r_cnt >= cfg_rd) begin
               ax.rvalid = 1'b1;
               ax.rdata  = cfg_rdata;
               ax.rresp  = cfg_rresp;
               pending_r = 0;
            end else r_cnt++;
         end else if (!pending_r && junk_en && $urandom_range(0, 1) == 1) begin
            ax.rvalid = 1'b1;
            ax.rdata  = {$urandom, $urandom};
            ax.rresp  = 2'($urandom_range(0, 3));
         end
         ax.arready = 1'b0;
         if (ax.arvalid) begin
            if (ar_cnt >= cfg_ard) begin
               ax.arready = 1'b1;
               ar_hs++;
               hs_addr   = ax.araddr;
               pending_r = 1;
               r_cnt     = 0;
               ar_cnt    = 0;
            end else ar_cnt++;
         end else if (junk_en) begin
            ax.arready = ($urandom_range(0, 1) == 1);
         end
      end
   endtask

   task automatic do_fetch(input vec_t v, input string name);
      int n;
      cfg_ard    = v.ard;
      cfg_rd     = v.rd;
      cfg_rdata  = v.rdata;
      cfg_rresp  = v.rresp;
      exp_araddr = v.addr;
      ar_hs = 0; arv_cycles = 0; done_cnt = 0; viol = 0;
      got_data = 64'hX; got_err = 1'bX; hs_addr = 64'd0;
      req      = 1'b1;
      req_addr = v.addr;
      n = 0;
      while (done_cnt == 0 && n < 200) begin
         step();
         n++;
         if (n == 1) req_addr = {$urandom, $urandom};
         if (!busy) viol++;
      end
      for (int i = 0; i < v.hold; i++) begin
         step();
         if (busy) viol++;
      end
      req = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         if (busy) viol++;
      end
      chk({name, " rd_done count"}, 64'(done_cnt), 64'd1);
      chk({name, " rd_data"}, got_data, v.exp_data);
      chk({name, " rd_err"}, 64'(got_err), 64'(v.exp_err));
      chk({name, " AR handshakes"}, 64'(ar_hs), 64'(v.exp_ar));
      chk({name, " arvalid cycles"}, 64'(arv_cycles), 64'(v.exp_ar == 1 ? v.ard + 1 : 0));
      chk({name, " latency"}, 64'(n), 64'(v.exp_ar == 1 ? 3 + v.ard + v.rd : 1));
      chk({name, " protocol/busy violations"}, 64'(viol), 64'd0);
      if (v.exp_ar == 1) chk({name, " araddr"}, hs_addr, v.addr);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, " arvalid"}, 64'(ax.arvalid), 64'd0);
      chk({name, " araddr"}, ax.araddr, 64'd0);
      chk({name, " rready"}, 64'(ax.rready), 64'd0);
      chk({name, " rd_done"}, 64'(rd_done), 64'd0);
      chk({name, " rd_data"}, rd_data, 64'd0);
      chk({name, " rd_err"}, 64'(rd_err), 64'd0);
      chk({name, " busy"}, 64'(busy), 64'd0);
   endtask

   vec_t tbl[8];

   initial begin
      vec_t v;
      int   k;

      tbl[0] = '{64'h8000_0000, 64'hDEAD_BEEF_0000_0413, 2'b00, 0, 0, 0, 64'h0000_0413, 1'b0, 1};
      tbl[1] = '{64'h8000_0004, 64'hDEAD_BEEF_0000_0413, 2'b00, 0, 0, 0, 64'hDEAD_BEEF, 1'b0, 1};
      tbl[2] = '{64'h8000_0000, 64'h1122_3344_5566_7788, 2'b01, 3, 4, 1, 64'h5566_7788, 1'b0, 1};
      tbl[3] = '{64'h8000_0000, 64'h0BAD_F00D_0000_0013, 2'b00, 0, 1, 10, 64'h0000_0013, 1'b0, 1};
      tbl[4] = '{64'h8000_0008, 64'hCAFE_F00D_1234_5678, 2'b00, 1, 0, 0, 64'h1234_5678, 1'b0, 1};
      tbl[5] = '{64'h8000_000C, 64'hAAAA_5555_0F0F_0F0F, 2'b11, 0, 2, 2, 64'hAAAA_5555, 1'b1, 1};
      tbl[6] = '{64'h8000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 0, 3, 64'h0, 1'b1, 0};
      tbl[7] = '{64'h8000_0010, 64'h7777_6666_5555_4444, 2'b10, 2, 0, 0, 64'h5555_4444, 1'b1, 1};

      rst = 1'b1; req = 1'b0; req_addr = 64'd0;
      ax.arready = 1'b0; ax.rvalid = 1'b0; ax.rdata = 64'd0; ax.rresp = 2'b00; ax.rlast = 1'b1;
      cfg_ard = 0; cfg_rd = 0; cfg_rdata = 64'd0; cfg_rresp = 2'b00; junk_en = 0;
      pending_r = 0; ar_cnt = 0; r_cnt = 0;
      ar_hs = 0; arv_cycles = 0; done_cnt = 0; viol = 0; exp_araddr = 64'd0;

      step();
      step();
      chk_all_zero("reset");
      chk("reset arlen", 64'(ax.arlen), 64'd0);
      chk("reset arsize", 64'(ax.arsize), 64'd2);
      chk("reset arburst", 64'(ax.arburst), 64'd1);
      rst = 1'b0;
      step();

      for (int i = 0; i < 8; i++) do_fetch(tbl[i], $sformatf("vec%0d", i));

      // Reset while waiting in the data phase, then a fresh fetch.
      cfg_ard = 0; cfg_rd = 8; cfg_rdata = 64'h0; cfg_rresp = 2'b00;
      exp_araddr = 64'h8000_0018;
      req = 1'b1; req_addr = 64'h8000_0018;
      k = 0;
      while (ax.rready !== 1'b1 && k < 20) begin step(); k++; end
      chk("midreset reached data phase", 64'(ax.rready), 64'd1);
      rst = 1'b1;
      step();
      chk_all_zero("midreset");
      rst = 1'b0;
      req = 1'b0;
      step();
      v = model('{64'h8000_0018, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0, 0, 64'd0, 1'b0, 0});
      do_fetch(v, "after-reset");

      // Randomized requests with junk traffic on idle channels.
      junk_en = 1;
      for (int i = 0; i < 24; i++) begin
         v.addr  = {32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom};
         if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
         v.rdata = {$urandom, $urandom};
         v.rresp = 2'($urandom_range(0, 3));
         v.ard   = $urandom_range(0, 4);
         v.rd    = $urandom_range(0, 4);
         v.hold  = $urandom_range(0, 3);
         v = model(v);
         do_fetch(v, $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/ifu_axi_rd_master.md
Name: ifu_axi_rd_master

Overview:
AXI4 read master directly upstream of the instruction fetch unit. It turns the fetch unit's level request (send signal and 64-bit PC address) into a single-beat AXI4 read, and returns the fetched instruction word right-aligned in bits [31:0] with a one-cycle done pulse. It also re-arms only after the fetch unit drops its request. This is needed because the fetch unit keeps its request high through its hold phase.

Parameters:
ADDR_W, 64, address width of request and AR channel
DATA_W, 64, AXI R data width; only 64 supported
ARSIZE_VAL, 3'b010, AXI burst size driven on arsize (4-byte fetch)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req  input  1  fetch request, level, from fetch unit send signal
req_addr  input  ADDR_W  fetch address (PC)
rd_done  output  1  one-cycle pulse: fetch complete, rd_data/rd_err valid
rd_data  output  DATA_W  fetched word; bits [31:0] = instruction, [63:32] = 0
rd_err  output  1  bus or alignment error for this fetch, valid with rd_done
busy  output  1  high from request acceptance until rd_done cycle inclusive
m_arvalid  output  1  AXI AR valid
m_araddr  output  ADDR_W  AXI AR address
m_arlen  output  8  constant 0
m_arsize  output  3  constant ARSIZE_VAL
m_arburst  output  2  constant 2'b01 (INCR)
m_arready  input  1  AXI AR ready
m_rvalid  input  1  AXI R valid
m_rready  output  1  AXI R ready
m_rdata  input  DATA_W  AXI R data
m_rresp  input  2  AXI R response
m_rlast  input  1  AXI R last (ignored; single beat)

Behaviour:
- Reset: state IDLE. All of m_arvalid, m_araddr, m_rready, rd_done, rd_data, rd_err and busy are 0. The AXI slave shares rst, so reset mid-transaction drops the outstanding read with no response expected.
- States: IDLE, ADDR, DATA, RESP, WAIT_REL.
- IDLE:
  - On req=1, latch req_addr into addr_q and set busy=1 on the next edge. Later changes on req_addr are ignored.
  - If req_addr[1:0]!=0 (misaligned), go to RESP with rd_err=1 and rd_data=0. No bus transaction is issued.
  - Otherwise go to ADDR, with m_arvalid=1 and m_araddr=addr_q registered on the same edge.
- ADDR: hold m_arvalid and m_araddr stable until m_arvalid&m_arready. On the handshake edge: m_arvalid goes to 0, m_rready goes to 1, next state is DATA.
- DATA:
  - On m_rvalid&m_rready, capture data and go to RESP. m_rready goes to 0 on that edge.
  - If addr_q[2]=1, rd_data={32'b0, m_rdata[63:32]}; otherwise rd_data={32'b0, m_rdata[31:0]}.
  - rd_err=1 when m_rresp is SLVERR(2'b10) or DECERR(2'b11). OKAY and EXOKAY give rd_err=0.
- RESP:
  - rd_done=1 for exactly this one cycle; busy stays 1. rd_data and rd_err hold until the next capture.
  - Next state is WAIT_REL.
- WAIT_REL: busy=0. Stay while req=1 and return to IDLE when req=0. This guarantees exactly one AXI read per request high-period.
- Minimum latency with m_arready=1 and m_rvalid one cycle after AR:
  - req sampled at edge 0, m_arvalid high in cycle 1, AR handshake in cycle 1.
  - rvalid in cycle 2, rd_done in cycle 3.
- No ordering between m_rvalid and state other than DATA. m_rvalid outside DATA is ignored, since rready=0.
- rd_done and m_arvalid are never high in the same cycle.
- The AXI outputs stay valid-stable until handshake, as AXI requires.

Decomposition:
- Shared package npc_axi_pkg holds:
  - AXI resp codes: OKAY, EXOKAY, SLVERR, DECERR.
  - Burst type and size constants.
  - The fetch-master state enum typedef.
- No sub-module; the FSM and datapath registers live in one module.

Test Plan:
- Aligned fetch: req=1, req_addr=0x80000000, arready=1, rvalid one cycle later, rdata=0xDEADBEEF_00000413, rresp=0 -> one AR with araddr=0x80000000, rd_done pulse, rd_data=0x00000413, rd_err=0.
- Upper word: req_addr=0x80000004, same rdata -> rd_data=0xDEADBEEF, rd_err=0.
- Backpressure: arready low 3 cycles, rvalid delayed 4 cycles -> arvalid/araddr stable throughout, exactly one AR handshake, rd_done once.
- Request held: req kept high 10 cycles after rd_done -> no second arvalid; drop req, raise again with 0x80000008 -> second read issued.
- Errors:
  - rresp=2'b11 -> rd_done with rd_err=1.
  - req_addr=0x80000002 -> rd_done with rd_err=1, rd_data=0, no arvalid ever asserted.
- Reset mid-transaction: rst=1 while in DATA -> next cycle all outputs 0, state IDLE; fresh req completes normally.
